msx_slot_rom_responder: RTL
===========================

Name: msx_slot_rom_responder

Overview:
- Bus-side responder for MSX cartridge-slot memory reads. Samples the asynchronous slot signals, fetches the byte from the internal FM ROM port, and drives it onto the slot data bus under direction control.
- Debug outputs (fmrom_state, fmrom_counter, fmrom_read, bus_data_reverse) go straight to the on-chip logic analyser.
- Sits between the slot pins and the FM ROM memory port, in the ex_clk_27m domain.

Parameters:
- ADDR_LO, 16'h4000, lowest decoded CPU address (inclusive)
- ADDR_HI, 16'hBFFF, highest decoded CPU address (inclusive)
- TIMEOUT, 20, FETCH cycles without rom_ack before 8'hFF is driven (1..31)
- RELEASE_CYCLES, 2, bus turnaround cycles after drive-off (1..31)

Ports:
- ex_clk_27m  in  1  sole clock
- ex_reset_n  in  1  synchronous active-low reset
- bus_reset_n  in  1  MSX bus reset, async, active low
- bus_sltsl_n  in  1  slot select, async, active low
- bus_mreq_n  in  1  memory request, async, active low
- bus_rd_n  in  1  read strobe, async, active low
- bus_addr  in  16  CPU address, async
- bus_data_out  out  8  byte presented to the slot data bus
- bus_data_reverse  out  1  1 = FPGA drives the data bus toward the CPU
- bus_wait_n  out  1  slot WAIT, active low (see Optional Feature)
- fmrom_read  out  1  ROM request, level
- fmrom_addr  out  15  ROM byte address = bus_addr - ADDR_LO
- fmrom_ack  in  1  one-cycle pulse, data valid
- fmrom_data  in  8  ROM byte, valid with fmrom_ack
- fmrom_state  out  2  FSM state: 0 IDLE, 1 FETCH, 2 DRIVE, 3 RELEASE
- fmrom_counter  out  5  FETCH/RELEASE cycle counter
- timeout_pulse  out  1  one-cycle pulse on FETCH timeout

Behaviour:
- Synchronisation:
  - Two-flop synchronisers on bus_reset_n, bus_sltsl_n, bus_mreq_n and bus_rd_n.
  - bus_addr is sampled once, on the cycle the FSM leaves IDLE. It is treated as stable by then.
- act = synced sltsl, mreq and rd all low.
- armed flag:
  - Set on any cycle with act = 0.
  - Cleared when a cycle is accepted.
  - Reset value 1.
- Reset (ex_reset_n = 0 at a clock edge) and synced bus_reset_n = 0 have the same effect:
  - State goes to IDLE and counter to 0.
  - fmrom_read = 0, bus_data_reverse = 0, bus_data_out = 8'hFF, bus_wait_n = 1, timeout_pulse = 0, armed = 1.
  - Applies from any state, including mid-FETCH and mid-DRIVE.
- IDLE:
  - If act, armed, and ADDR_LO <= bus_addr <= ADDR_HI:
    - Latch fmrom_addr = bus_addr - ADDR_LO (15-bit, truncated).
    - fmrom_read = 1, counter = 0, state goes to FETCH.
  - An address outside the window is ignored, armed is left unchanged, and no drive occurs.
- FETCH:
  - counter increments by 1 per cycle. fmrom_read stays high until exit.
  - fmrom_ack = 1: latch fmrom_data into bus_data_out, fmrom_read = 0, go to DRIVE.
  - act = 0 with no ack (abort): fmrom_read = 0, go to RELEASE, bus_data_reverse stays 0, data is discarded.
  - counter == TIMEOUT - 1 with no ack: bus_data_out = 8'hFF, timeout_pulse = 1 for one cycle, fmrom_read = 0, go to DRIVE.
  - Priority when events coincide: ack, then abort, then timeout.
- DRIVE:
  - bus_data_reverse = 1, registered: asserted the first cycle in DRIVE.
  - bus_data_out is held constant.
  - When act = 0: bus_data_reverse = 0 on the next edge, counter = 0, go to RELEASE.
- RELEASE:
  - counter increments.
  - At counter == RELEASE_CYCLES - 1, go to IDLE.
  - A new cycle is not accepted until IDLE; armed guarantees one response per strobe.
- fmrom_ack outside FETCH is ignored.
- Latency, CPU strobe to bus_data_reverse = 1 (ack in FETCH cycle k, k >= 1): 2 sync + 1 accept + k + 1 cycles.
- fmrom_state and fmrom_counter are the registered FSM values.

Optional Feature:
- Macro: MSX_SLOT_WAIT_EN.
- Defined:
  - bus_wait_n = 0 from the IDLE->FETCH edge until the FETCH->DRIVE edge.
  - Forced to 1 on abort, on reset, and in every other state.
- Undefined: bus_wait_n is tied to 1, and no wait logic is synthesised.

Test Plan:
- Normal read: bus_addr = 16'h4123, slot/mreq/rd low, ack after 3 FETCH cycles with data 8'hA5:
  - fmrom_addr = 15'h0123.
  - bus_data_out = 8'hA5 and bus_data_reverse = 1 until rd_n rises.
  - Then 2 RELEASE cycles, then IDLE.
- Out of window: bus_addr = 16'h3FFF or 16'hC000:
  - fmrom_read stays 0, bus_data_reverse stays 0, state stays 0.
- Timeout: no ack, TIMEOUT = 20:
  - timeout_pulse high exactly 20 FETCH cycles after entry.
  - bus_data_out = 8'hFF, bus_data_reverse = 1.
- Abort: rd_n rises at FETCH counter = 2 before ack:
  - fmrom_read drops, state goes to RELEASE, bus_data_reverse never 1.
  - A late ack is ignored.
- Reset mid-DRIVE:
  - ex_reset_n low for 1 cycle: state = 0, bus_data_reverse = 0, bus_data_out = 8'hFF next edge.
  - Repeat with bus_reset_n low for 3 cycles: same result 2 cycles later.
- Back-to-back: second strobe asserted during RELEASE:
  - Accepted on first IDLE cycle.
  - Strobe held low across IDLE: no second response (armed).
  - With MSX_SLOT_WAIT_EN: bus_wait_n low throughout FETCH only.

Source files
------------

// File: rtl/msx_slot_rom_responder_if.sv
// Slot-bus and FM ROM port bundle for msx_slot_rom_responder.
// The responder takes the slave modport; the bus/ROM side takes the master modport.
interface msx_slot_rom_responder_if;
  logic        bus_reset_n;
  logic        bus_sltsl_n;
  logic        bus_mreq_n;
  logic        bus_rd_n;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_data_reverse;
  logic        bus_wait_n;
  logic        fmrom_read;
  logic [14:0] fmrom_addr;
  logic        fmrom_ack;
  logic [7:0]  fmrom_data;
  logic [1:0]  fmrom_state;
  logic [4:0]  fmrom_counter;
  logic        timeout_pulse;

  modport slave (
    input  bus_reset_n, bus_sltsl_n, bus_mreq_n, bus_rd_n, bus_addr,
    input  fmrom_ack, fmrom_data,
    output bus_data_out, bus_data_reverse, bus_wait_n,
    output fmrom_read, fmrom_addr, fmrom_state, fmrom_counter, timeout_pulse
  );

  modport master (
    output bus_reset_n, bus_sltsl_n, bus_mreq_n, bus_rd_n, bus_addr,
    output fmrom_ack, fmrom_data,
    input  bus_data_out, bus_data_reverse, bus_wait_n,
    input  fmrom_read, fmrom_addr, fmrom_state, fmrom_counter, timeout_pulse
  );
endinterface

// File: rtl/msx_slot_rom_responder.sv
// MSX cartridge-slot read responder: syncs slot strobes, fetches from FM ROM, drives the data bus.
// Optional slot WAIT generation during FETCH is enabled by defining MSX_SLOT_WAIT_EN.
module msx_slot_rom_responder #(
  parameter logic [15:0] ADDR_LO        = 16'h4000,
  parameter logic [15:0] ADDR_HI        = 16'hBFFF,
  parameter int          TIMEOUT        = 20,
  parameter int          RELEASE_CYCLES = 2
) (
  input  logic                           ex_clk_27m,
  input  logic                           ex_reset_n,
  msx_slot_rom_responder_if.slave        slot
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DRIVE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT - 1);
  localparam logic [4:0] RELEASE_LAST = 5'(RELEASE_CYCLES - 1);

  logic [1:0]  reset_sync;
  logic [1:0]  sltsl_sync;
  logic [1:0]  mreq_sync;
  logic [1:0]  rd_sync;

  state_t      state;
  logic [4:0]  counter;
  logic        armed;
  logic        fmrom_read_q;
  logic        reverse_q;
  logic [7:0]  data_out_q;
  logic [14:0] fmrom_addr_q;
  logic        timeout_q;

  logic        act;
  logic        in_window;

  // Sync flops idle high so a local reset never looks like an active strobe.
  always_ff @(posedge ex_clk_27m) begin
    if (!ex_reset_n) begin
      reset_sync <= 2'b11;
      sltsl_sync <= 2'b11;
      mreq_sync  <= 2'b11;
      rd_sync    <= 2'b11;
    end else begin
      reset_sync <= {reset_sync[0], slot.bus_reset_n};
      sltsl_sync <= {sltsl_sync[0], slot.bus_sltsl_n};
      mreq_sync  <= {mreq_sync[0],  slot.bus_mreq_n};
      rd_sync    <= {rd_sync[0],    slot.bus_rd_n};
    end
  end

  assign act       = ~sltsl_sync[1] & ~mreq_sync[1] & ~rd_sync[1];
  assign in_window = (slot.bus_addr >= ADDR_LO) && (slot.bus_addr <= ADDR_HI);

  always_ff @(posedge ex_clk_27m) begin
    if (!ex_reset_n || !reset_sync[1]) begin
      state        <= IDLE;
      counter      <= 5'd0;
      armed        <= 1'b1;
      fmrom_read_q <= 1'b0;
      reverse_q    <= 1'b0;
      data_out_q   <= 8'hFF;
      fmrom_addr_q <= 15'd0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (!act) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (act && armed && in_window) begin
            fmrom_addr_q <= 15'(slot.bus_addr - ADDR_LO);
            fmrom_read_q <= 1'b1;
            counter      <= 5'd0;
            armed        <= 1'b0;
            state        <= FETCH;
          end
        end
        // Ack wins over abort, abort wins over timeout.
        FETCH: begin
          counter <= counter + 5'd1;
          if (slot.fmrom_ack) begin
            data_out_q   <= slot.fmrom_data;
            fmrom_read_q <= 1'b0;
            reverse_q    <= 1'b1;
            state        <= DRIVE;
          end else if (!act) begin
            fmrom_read_q <= 1'b0;
            counter      <= 5'd0;
            state        <= RELEASE;
          end else if (counter == TIMEOUT_LAST) begin
            data_out_q   <= 8'hFF;
            timeout_q    <= 1'b1;
            fmrom_read_q <= 1'b0;
            reverse_q    <= 1'b1;
            state        <= DRIVE;
          end
        end
        DRIVE: begin
          if (!act) begin
            reverse_q <= 1'b0;
            counter   <= 5'd0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (counter == RELEASE_LAST) begin
            counter <= 5'd0;
            state   <= IDLE;
          end else begin
            counter <= counter + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign slot.bus_data_out     = data_out_q;
  assign slot.bus_data_reverse = reverse_q;
  assign slot.fmrom_read       = fmrom_read_q;
  assign slot.fmrom_addr       = fmrom_addr_q;
  assign slot.fmrom_state      = state;
  assign slot.fmrom_counter    = counter;
  assign slot.timeout_pulse    = timeout_q;

`ifdef MSX_SLOT_WAIT_EN
  // State leaves FETCH on ack, timeout, abort and reset alike, so WAIT follows it directly.
  assign slot.bus_wait_n = (state != FETCH);
`else
  assign slot.bus_wait_n = 1'b1;
`endif

endmodule
